// File: rtl/rissy_pkg.sv
// Shared definitions for the Rissy 16-bit core: widths, opcodes and the
// fetch-stage state encoding.
package rissy_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  // Major opcodes live in the top nibble of every instruction.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_NDU = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_SW  = 4'h5;
  localparam logic [3:0] OP_JAL = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'hC;

  // Fetch FSM encoding.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;  // no request outstanding
  localparam fetch_state_t ST_REQ   = 2'd1;  // live request at fetch_pc
  localparam fetch_state_t ST_DRAIN = 2'd2;  // stale request, data discarded

  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} entries between the
// instruction-memory port and the decoder. Flush empties it in one cycle.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage, pointers and occupancy; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset so the head outputs read zero, not X, after reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_valid     = (r_count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack word reads to
// instruction memory, buffers {inst, pc} for the decoder, and handles
// branch/JAL redirects by flushing and squashing any in-flight read.
module fetch_unit
  import rissy_pkg::*;
#(
  parameter int              ADDR_W   = rissy_pkg::ADDR_W,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = INST_W + ADDR_W;

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_drain_addr;

  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_pop;
  logic               w_push;
  logic               w_space;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_after;
  logic [ENTRY_W-1:0] w_head;

  // Only a live request's data is kept; a redirect in the same cycle drops it.
  assign w_pop         = inst_valid && inst_ready;
  assign w_push        = (r_state == ST_REQ) && imem_ack && !redirect;
  assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_space       = (w_count_after < CNT_W'(DEPTH));

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({imem_rdata, r_fetch_pc}),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_valid     (inst_valid)
  );

  // Next state and next PC; redirect wins over everything else.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    w_state_next = r_state;
    w_pc_next    = r_fetch_pc;
    case (r_state)
      ST_IDLE: begin
        if (redirect) begin
          w_pc_next    = redirect_pc;
          w_state_next = ST_REQ;
        end else if (w_space) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          w_pc_next    = redirect_pc;
          w_state_next = imem_ack ? ST_REQ : ST_DRAIN;
        end else if (imem_ack) begin
          w_pc_next    = r_fetch_pc + ADDR_W'(1);
          w_state_next = w_space ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect) w_pc_next = redirect_pc;
        if (imem_ack) w_state_next = ST_REQ;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM, PC, and the stale address held while a squashed read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_pc_next;
      if ((r_state == ST_REQ) && redirect && !imem_ack) r_drain_addr <= r_fetch_pc;
    end
  end

  assign imem_req  = (r_state != ST_IDLE);
  assign imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_fetch_pc;
  assign inst      = w_head[ENTRY_W-1 -: INST_W];
  assign inst_pc   = w_head[ADDR_W-1:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Rissy 16-bit core, directly upstream of the instruction decoder. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Returned instructions and their PCs are buffered in a small FIFO, which the decoder drains with valid/ready. Branch and JAL resolution redirects the PC, flushes the buffer and squashes any in-flight read.

## Interface
- ADDR_W, 16, PC / instruction-memory word-address width
- DEPTH, 2, prefetch buffer entries (power of two, ≥2)
- RESET_PC, 16'h0000, PC after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request; held high until imem_ack
- imem_addr  out  ADDR_W  word address; stable while imem_req high
- imem_ack  in  1  read done this cycle; may assert in the first req cycle
- imem_rdata  in  16  instruction, valid when imem_ack
- redirect  in  1  one-cycle pulse: branch taken / JAL
- redirect_pc  in  ADDR_W  target PC, valid with redirect
- inst_valid  out  1  buffer head holds an instruction
- inst_ready  in  1  decoder accepts head this cycle
- inst  out  16  head instruction
- inst_pc  out  ADDR_W  PC of head instruction

## Operation
- Registers: fetch_pc, state, FIFO (entries of {inst, pc}, count 0..DEPTH).
- States: IDLE (no request), REQ (live request at fetch_pc), DRAIN (request in flight whose data must be discarded).
- imem_req = (state != IDLE); imem_addr = fetch_pc in IDLE/REQ, latched old address in DRAIN.
- IDLE → REQ when count < DEPTH (after pop accounted) and no redirect.
- REQ, ack, no redirect: push {imem_rdata, fetch_pc}; fetch_pc += 1 (wraps 16'hFFFF → 0); → REQ if space remains after push/pop, else IDLE.
- REQ, no ack, no redirect: stay; address held.
- redirect in IDLE: fetch_pc ← redirect_pc; flush; → REQ.
- redirect in REQ with ack same cycle: data dropped; fetch_pc ← redirect_pc; flush; → REQ.
- redirect in REQ without ack: fetch_pc ← redirect_pc; flush; → DRAIN; old address held until ack.
- DRAIN, ack: data dropped; → REQ at new fetch_pc. A further redirect in DRAIN only updates fetch_pc.
- Priority in a cycle: redirect > push > pop. Flush empties FIFO regardless of simultaneous pop/push.
- Pop when inst_valid && inst_ready. Simultaneous push and pop at count == DEPTH is not possible (no request issued when full); at count 0 no bypass — pushed data appears next cycle.
- inst/inst_pc when inst_valid = 0 are don't-care but must not be X after reset.

## Timing
- Reset (async assert, sync release): state IDLE, fetch_pc = RESET_PC, count 0; imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0.
- First imem_req in the first cycle after reset release.
- Zero-wait memory: ack in req cycle N → inst_valid at N+1; sustained throughput 1 instr/cycle with inst_ready held high.
- Redirect at cycle N: inst_valid = 0 at N+1; with no read in flight, imem_req at redirect_pc at N+1, first target instruction valid at N+2.
- Reset asserted mid-request abandons it; memory must tolerate a dropped req.

## Structure
- Shared rissy_pkg: ADDR_W, instruction width (16), opcode constants (ADD 4'h0, NDU 4'h2, LW 4'h4, SW 4'h5, JAL 4'h8, BEQ 4'hC), fetch state enum.
- One sub-module: fetch_fifo (parametric {inst, pc} FIFO with push, pop, flush, count).

## Test plan
- Reset release, zero-wait memory returning mem[a]=16'h1000+a, inst_ready=1 → inst_pc 0,1,2,3 on consecutive cycles, inst 16'h1000.., one per cycle after first.
- inst_ready=0 for 5 cycles → buffer fills to 2 (pc 0,1), imem_req drops; resume → pc 0,1,2 in order, none lost or duplicated.
- 3-wait-state memory, redirect to 16'h0040 on cycle 1 of a pending read at pc 5 → addr 5 held until ack, data discarded, next request addr 16'h0040, first inst_pc 16'h0040.
- redirect to 16'h0010 while 2 entries buffered and inst_ready=1 → inst_valid 0 next cycle, next delivered inst_pc 16'h0010.
- redirect_pc 16'hFFFE, zero-wait → inst_pc FFFE, FFFF, 0000, 0001.
- rst_n pulsed low mid-request → outputs at reset values immediately, fetch restarts at RESET_PC.
